// File: rtl/demux1to16_buffered.sv
// demux1to16_buffered: steers one WIDTH-bit stream to 16 buffered channels.
// Each channel is a one-entry register with a valid/ready handshake.
// Optional macro DEMUX_BCAST_EN adds the in_bcast port for broadcast writes.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_data/in_sel      - byte to route and its destination channel
//   in_valid/in_ready   - producer handshake
//   out_data/out_valid  - channel k data at [k*WIDTH +: WIDTH], valid bit k
//   out_ready           - consumer k takes its byte
//   occupancy           - number of full channels (0..16)
//   in_bcast            - load all channels (DEMUX_BCAST_EN only)
module demux1to16_buffered #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [3:0]          in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [16*WIDTH-1:0] out_data,
    output logic [15:0]         out_valid,
    input  logic [15:0]         out_ready,
`ifdef DEMUX_BCAST_EN
    input  logic                in_bcast,
`endif
    output logic [4:0]          occupancy
);

    logic [15:0] drain;
    logic [15:0] free;
    logic [15:0] load;
    logic [15:0] valid_nxt;
    logic [4:0]  occ_nxt;
    logic        accept;

    always_comb begin
        drain  = out_valid & out_ready;
        // A channel can take a byte if empty or being drained this cycle.
        free   = ~out_valid | out_ready;
        load   = '0;
`ifdef DEMUX_BCAST_EN
        // Broadcast needs every channel free at once; select is ignored.
        in_ready = in_bcast ? (&free) : free[in_sel];
        accept   = in_valid & in_ready;
        if (accept) begin
            if (in_bcast) begin
                load = '1;
            end else begin
                load[in_sel] = 1'b1;
            end
        end
`else
        in_ready = free[in_sel];
        accept   = in_valid & in_ready;
        if (accept) begin
            load[in_sel] = 1'b1;
        end
`endif
        valid_nxt = (out_valid & ~drain) | load;
        // Count only real transitions: fills of empty channels and
        // drains that are not refilled in the same cycle.
        occ_nxt = occupancy;
        for (int k = 0; k < 16; k++) begin
            if (load[k] && !out_valid[k]) begin
                occ_nxt = occ_nxt + 5'd1;
            end
            if (drain[k] && !load[k]) begin
                occ_nxt = occ_nxt - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
            occupancy <= '0;
        end else begin
            out_valid <= valid_nxt;
            occupancy <= occ_nxt;
            for (int k = 0; k < 16; k++) begin
                if (load[k]) begin
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux1to16_buffered.sv
// tb_demux1to16_buffered: directed bench with an accept scoreboard.
// Defining DEMUX_BCAST_EN also exercises the broadcast path.
module tb_demux1to16_buffered;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic [3:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [15:0]  out_valid;
    logic [15:0]  out_ready;
    logic [4:0]   occupancy;
`ifdef DEMUX_BCAST_EN
    logic         in_bcast = 1'b0;
`endif

    typedef struct {
        logic [3:0] ch;
        logic [7:0] d;
    } item_t;

    item_t       sbq[$];
    logic [15:0] mv;
    int          nvec = 0;
    int          nerr = 0;

    demux1to16_buffered #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] s,
                        input logic [7:0] d, input logic v,
                        input logic [15:0] rd);
        logic  er;
        logic  acc;
        item_t it;
        reset     = r;
        in_sel    = s;
        in_data   = d;
        in_valid  = v;
        out_ready = rd;
        #1;
        er = ~mv[s] | rd[s];
        chk("in_ready", {31'b0, in_ready}, {31'b0, er});
        acc = v & er & ~r;
        if (acc) sbq.push_back('{s, d});
        if (r) begin
            mv = '0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (acc && k == int'(s)) mv[k] = 1'b1;
                else if (rd[k]) mv[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {16'b0, out_valid}, {16'b0, mv});
        chk("occupancy", {27'b0, occupancy}, $countones(mv));
        if (acc) begin
            it = sbq.pop_front();
            chk("data", {24'b0, out_data[int'(it.ch)*8 +: 8]}, {24'b0, it.d});
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = '0;
    endtask

    initial begin
        mv        = '0;
        reset     = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", {16'b0, out_valid}, 32'h0);
        chk("rst_occ", {27'b0, occupancy}, 32'h0);
        for (int s = 0; s < 16; s++) begin
            in_sel = 4'(s);
            #1;
            chk("idle_ready", {31'b0, in_ready}, 32'h1);
        end

        // single send, then blocked second send
        step(1'b0, 4'd3, 8'hA5, 1'b1, 16'h0);
        chk("ch3_valid", {16'b0, out_valid}, 32'h0008);
        chk("ch3_byte", {24'b0, out_data[31:24]}, 32'hA5);
        step(1'b0, 4'd3, 8'h77, 1'b1, 16'h0);
        chk("ch3_hold", {24'b0, out_data[31:24]}, 32'hA5);

        // fill all channels, then drain all at once
        step(1'b1, 4'd0, 8'h00, 1'b0, 16'h0);
        for (int k = 0; k < 16; k++)
            step(1'b0, 4'(k), 8'(8'h10 + k), 1'b1, 16'h0);
        chk("full_occ", {27'b0, occupancy}, 32'd16);
        chk("full_valid", {16'b0, out_valid}, 32'hFFFF);
        for (int s = 0; s < 16; s++) begin
            in_sel = 4'(s);
            #1;
            chk("full_ready", {31'b0, in_ready}, 32'h0);
        end
        chk("ch15_byte", {24'b0, out_data[127:120]}, 32'h1F);
        step(1'b0, 4'd0, 8'h00, 1'b0, 16'hFFFF);
        chk("drain_occ", {27'b0, occupancy}, 32'd0);

        // same-cycle replace on ch 7
        step(1'b0, 4'd7, 8'h55, 1'b1, 16'h0);
        step(1'b0, 4'd7, 8'h66, 1'b1, 16'h0080);
        chk("rep_byte", {24'b0, out_data[63:56]}, 32'h66);
        chk("rep_occ", {27'b0, occupancy}, 32'd1);

        // accept into ch 2 while ch 9 and ch 12 drain
        step(1'b1, 4'd0, 8'h00, 1'b0, 16'h0);
        step(1'b0, 4'd9, 8'h91, 1'b1, 16'h0);
        step(1'b0, 4'd12, 8'hC1, 1'b1, 16'h0);
        step(1'b0, 4'd14, 8'hE1, 1'b1, 16'h0);
        step(1'b0, 4'd2, 8'h21, 1'b1, 16'h1200);
        chk("mix_occ", {27'b0, occupancy}, 32'd2);
        chk("mix_valid", {16'b0, out_valid}, 32'h4004);

        // reset mid-traffic with an accept pending
        step(1'b1, 4'd0, 8'h00, 1'b0, 16'h0);
        for (int k = 0; k < 5; k++)
            step(1'b0, 4'(k), 8'(8'h40 + k), 1'b1, 16'h0);
        chk("pre_occ", {27'b0, occupancy}, 32'd5);
        step(1'b1, 4'd8, 8'hEE, 1'b1, 16'h0);
        chk("mid_valid", {16'b0, out_valid}, 32'h0);
        chk("mid_occ", {27'b0, occupancy}, 32'd0);
        step(1'b0, 4'd8, 8'h00, 1'b0, 16'h0);
        chk("not_stored", {31'b0, out_valid[8]}, 32'h0);

`ifdef DEMUX_BCAST_EN
        in_bcast = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_sel   = 4'd5;
        #1;
        chk("bc_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_bcast = 1'b0;
        in_valid = 1'b0;
        chk("bc_occ", {27'b0, occupancy}, 32'd16);
        chk("bc_valid", {16'b0, out_valid}, 32'hFFFF);
        for (int k = 0; k < 16; k++)
            chk("bc_byte", {24'b0, out_data[k*8 +: 8]}, 32'h3C);
`endif

        chk("sb_empty", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
